// File: rtl/clk_en_reset_gen.sv
// Lock-qualified clock-enable and staggered reset sequencer for one fast PLL clock domain.
// Optional saturating lock-loss counter is built only when LOCK_LOSS_CNT_EN is defined.
module clk_en_reset_gen #(
  parameter int                          NUM_CH             = 4,
  parameter int                          DIV_W              = 8,
  parameter logic [NUM_CH*DIV_W-1:0]     CH_DIV             = {8'd10, 8'd5, 8'd2, 8'd1},
  parameter int                          LOCK_STABLE_CYCLES = 1024,
  parameter int                          RST_STAGGER        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] ch_rst,
  output logic              all_ready,
  output logic              lock_lost,
  output logic [7:0]        lock_loss_count
);

  // state      | meaning
  // WAIT_LOCK  | waiting for synchronised lock
  // STABILIZE  | counting consecutive locked cycles
  // RELEASE    | enables running, channel resets falling one by one
  // RUN        | every channel out of reset
  typedef enum logic [1:0] {WAIT_LOCK, STABILIZE, RELEASE, RUN} state_t;

  localparam int STAB_W   = $clog2(LOCK_STABLE_CYCLES);
  localparam int ELAP_MAX = (NUM_CH - 1) * RST_STAGGER;
  localparam int ELAP_W   = $clog2(ELAP_MAX + 2);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);

  state_t              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                locked_s_q, locked_s_d;
  logic [STAB_W-1:0]   stab_cnt_q, stab_cnt_d;
  logic [ELAP_W-1:0]   elapsed_q, elapsed_d;
  logic [NUM_CH-1:0]   hold_q, hold_d;
  logic                lock_lost_q, lock_lost_d;
  logic [DIV_W-1:0]    div_cnt_q [NUM_CH];
  logic [DIV_W-1:0]    div_cnt_d [NUM_CH];

  logic                active;
  logic [NUM_CH-1:0]   ce_c;
  logic [NUM_CH-1:0]   ch_rst_c;
  logic                all_ready_c;
  logic [31:0]         elapsed_now;

  always_comb begin
    sync1_d     = pll_locked;
    locked_s_d  = sync1_q;
    state_d     = state_q;
    stab_cnt_d  = stab_cnt_q;
    elapsed_d   = '0;
    hold_d      = '1;
    lock_lost_d = 1'b0;
    for (int i = 0; i < NUM_CH; i++) div_cnt_d[i] = '0;

    active = (state_q == RELEASE) || (state_q == RUN);
    // Elapsed is reported counting the RELEASE entry cycle as 1.
    elapsed_now = 32'(elapsed_q) + 32'd1;
    for (int i = 0; i < NUM_CH; i++) begin
      ce_c[i]     = active && (div_cnt_q[i] == (CH_DIV[i*DIV_W +: DIV_W] - DIV_W'(1)));
      ch_rst_c[i] = active ? (hold_q[i] && !(ce_c[i] &&
                    (elapsed_now >= 32'(i * RST_STAGGER)))) : 1'b1;
    end
    all_ready_c = (state_q == RUN) || ((state_q == RELEASE) && (ch_rst_c == '0));

    case (state_q)
      WAIT_LOCK: begin
        stab_cnt_d = '0;
        if (locked_s_q) state_d = STABILIZE;
      end
      STABILIZE: begin
        if (!locked_s_q) begin
          state_d    = WAIT_LOCK;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d    = RELEASE;
          stab_cnt_d = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
      end
      RELEASE, RUN: begin
        if (!locked_s_q) begin
          state_d     = WAIT_LOCK;
          lock_lost_d = 1'b1;
        end else begin
          hold_d    = ch_rst_c;
          elapsed_d = (elapsed_q == ELAP_W'(ELAP_MAX)) ? elapsed_q : elapsed_q + ELAP_W'(1);
          for (int i = 0; i < NUM_CH; i++)
            div_cnt_d[i] = ce_c[i] ? '0 : div_cnt_q[i] + DIV_W'(1);
          if (state_q == RELEASE && all_ready_c) state_d = RUN;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_LOCK;
      sync1_q     <= 1'b0;
      locked_s_q  <= 1'b0;
      stab_cnt_q  <= '0;
      elapsed_q   <= '0;
      hold_q      <= '1;
      lock_lost_q <= 1'b0;
      div_cnt_q   <= '{default: '0};
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      locked_s_q  <= locked_s_d;
      stab_cnt_q  <= stab_cnt_d;
      elapsed_q   <= elapsed_d;
      hold_q      <= hold_d;
      lock_lost_q <= lock_lost_d;
      div_cnt_q   <= div_cnt_d;
    end
  end

`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lock_lost_q && loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) loss_cnt_q <= 8'd0;
    else     loss_cnt_q <= loss_cnt_d;
  end

  assign lock_loss_count = loss_cnt_q;
`else
  assign lock_loss_count = 8'd0;
`endif

  assign ce        = ce_c;
  assign ch_rst    = ch_rst_c;
  assign all_ready = all_ready_c;
  assign lock_lost = lock_lost_q;

endmodule
